rr_merge: RTL and testbench

RR_MERGE -- requirements
Module: rr_merge

---
 rtl/rr_merge.sv | 136 +++++++++++++
 tb/tb_rr_merge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_merge.sv
// Round-robin N:1 merge with packet lock and a single registered output slot.
// A lane that starts a multi-word packet owns the output until its last word.
module rr_merge #(
    parameter int S = 3,
    parameter int T = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [(1<<S)-1:0]      in_valid,
    input  logic [(1<<S)*T-1:0]    in_data,
    input  logic [(1<<S)-1:0]      in_last,
    output logic [(1<<S)-1:0]      in_ready,
    output logic                   out_valid,
    output logic [T-1:0]           out_data,
    output logic [S-1:0]           out_sel,
    output logic                   out_last,
    input  logic                   out_ready
);

    localparam int N = 1 << S;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [S-1:0] ptr_q, ptr_d;
    logic [S-1:0] lk_q, lk_d;
    logic         out_valid_q, out_valid_d;
    logic [T-1:0] out_data_q, out_data_d;
    logic [S-1:0] out_sel_q, out_sel_d;
    logic         out_last_q, out_last_d;

    logic         can_load;
    logic         found;
    logic [S-1:0] gnt;
    logic [S-1:0] idx;
    logic [S-1:0] src;
    logic         acc;
    logic         src_last;

    assign can_load = ~out_valid_q | out_ready;

    // Rotating priority scan starting at ptr; S-bit add wraps modulo N.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + S'(k);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        lk_d     = lk_q;
        in_ready = '0;
        src      = '0;
        unique case (state_q)
            IDLE: begin
                src = gnt;
                if (can_load && found) begin
                    in_ready[gnt] = 1'b1;
                end
            end
            LOCK: begin
                src = lk_q;
                in_ready[lk_q] = can_load & in_valid[lk_q];
            end
            default: begin
                src = '0;
            end
        endcase
        if (rst) begin
            in_ready = '0;
        end
        acc      = |in_ready;
        src_last = in_last[src];
        if (acc) begin
            if (src_last) begin
                state_d = IDLE;
                ptr_d   = src + S'(1);
            end else begin
                state_d = LOCK;
                lk_d    = src;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(src)*T +: T];
            out_sel_d   = src;
            out_last_d  = src_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lk_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lk_q        <= lk_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_merge.sv
// Directed bench for rr_merge at S=2, T=8.
// Inputs change 1 time unit after each rising edge; checks follow 1 unit later.
module tb_rr_merge;

    localparam int S = 2;
    localparam int T = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*T-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [T-1:0]   out_data;
    logic [S-1:0]   out_sel;
    logic           out_last;
    logic           out_ready;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rr_merge #(.S(S), .T(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    // Demux downstream of the merge: word lands on lane out_sel.
    function automatic logic [31:0] dmx();
        logic [31:0] v;
        v = '0;
        if (out_valid) v[int'(out_sel)*8 +: 8] = out_data;
        return v;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        nxt();
        #1;
        chk("rst_rdy",   32'(in_ready),  32'h0);
        chk("rst_vld",   32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_sel",   32'(out_sel),   32'h0);
        chk("rst_last",  32'(out_last),  32'h0);

        // single-word fairness
        rst = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            chk("fair_rdy", 32'(in_ready), 32'(1 << (j % 4)));
            if (j > 0) begin
                chk("fair_sel",  32'(out_sel),  32'((j - 1) % 4));
                chk("fair_data", 32'(out_data), 32'(8'h10 + (j - 1) % 4));
                chk("fair_dmx",  dmx(),
                    32'(8'h10 + (j - 1) % 4) << (8 * ((j - 1) % 4)));
            end
            nxt();
        end
        in_valid = '0;
        #1;
        chk("fair_sel4", 32'(out_sel),   32'h0);
        chk("fair_vld4", 32'(out_valid), 32'h1);
        chk("idle_rdy",  32'(in_ready),  32'h0);
        nxt();
        chk("drain_vld", 32'(out_valid), 32'h0);

        // packet lock on lane 2
        do_reset();
        in_valid = 4'b0010;
        in_last  = 4'b0011;
        in_data  = 32'h00000100;
        #1;
        chk("pk_pre", 32'(in_ready), 32'b0010);
        nxt();
        in_valid = 4'b0111;
        in_data  = 32'h00200100;
        #1;
        chk("pk_w0_rdy", 32'(in_ready), 32'b0100);
        nxt();
        in_valid = 4'b0011;
        #1;
        chk("pk_gap_rdy",  32'(in_ready), 32'b0000);
        chk("pk_w0_sel",   32'(out_sel),  32'h2);
        chk("pk_w0_data",  32'(out_data), 32'h20);
        chk("pk_w0_last",  32'(out_last), 32'h0);
        nxt();
        in_valid = 4'b0111;
        in_data  = 32'h00210100;
        #1;
        chk("pk_gap_vld", 32'(out_valid), 32'h0);
        chk("pk_w1_rdy",  32'(in_ready),  32'b0100);
        nxt();
        in_data = 32'h00220100;
        in_last = 4'b0111;
        #1;
        chk("pk_w2_rdy",  32'(in_ready), 32'b0100);
        chk("pk_w1_sel",  32'(out_sel),  32'h2);
        chk("pk_w1_data", 32'(out_data), 32'h21);
        nxt();
        in_valid = 4'b0011;
        in_last  = 4'b0011;
        #1;
        chk("pk_rel_rdy", 32'(in_ready), 32'b0001);
        chk("pk_w2_data", 32'(out_data), 32'h22);
        chk("pk_w2_last", 32'(out_last), 32'h1);
        nxt();
        chk("pk_nx_sel",  32'(out_sel),  32'h0);
        chk("pk_nx_data", 32'(out_data), 32'h00);

        // backpressure
        do_reset();
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        in_data  = 32'h000000A5;
        #1;
        chk("bp_load", 32'(in_ready), 32'b0001);
        nxt();
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        in_last   = 4'b0011;
        in_data   = 32'h00005AA6;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_vld",  32'(out_valid), 32'h1);
            chk("bp_data", 32'(out_data),  32'hA5);
            chk("bp_sel",  32'(out_sel),   32'h0);
            chk("bp_rdy",  32'(in_ready),  32'h0);
            nxt();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy",  32'(in_ready), 32'b0010);
        chk("bp_rel_data", 32'(out_data), 32'hA5);
        nxt();
        chk("bp_nx_data", 32'(out_data),  32'h5A);
        chk("bp_nx_sel",  32'(out_sel),   32'h1);
        chk("bp_nx_vld",  32'(out_valid), 32'h1);

        // pointer wrap 3 -> 0
        do_reset();
        in_valid = 4'b1000;
        in_last  = 4'b1111;
        in_data  = 32'h33000030;
        #1;
        chk("wr_l3", 32'(in_ready), 32'b1000);
        nxt();
        in_valid = 4'b1001;
        #1;
        chk("wr_l0",     32'(in_ready), 32'b0001);
        chk("wr_l3_sel", 32'(out_sel),  32'h3);
        chk("wr_l3_dat", 32'(out_data), 32'h33);
        nxt();
        chk("wr_l3b",    32'(in_ready), 32'b1000);
        chk("wr_l0_sel", 32'(out_sel),  32'h0);
        chk("wr_l0_dat", 32'(out_data), 32'h30);
        nxt();
        chk("wr_l3b_sel", 32'(out_sel), 32'h3);

        // reset mid-packet
        do_reset();
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        in_data  = 32'h00004100;
        #1;
        chk("rm_lock", 32'(in_ready), 32'b0010);
        nxt();
        rst      = 1'b1;
        in_valid = 4'b0011;
        #1;
        chk("rm_rst_rdy", 32'(in_ready), 32'h0);
        chk("rm_held",    32'(out_data), 32'h41);
        nxt();
        rst     = 1'b0;
        in_last = 4'b0011;
        in_data = 32'h00004240;
        #1;
        chk("rm_vld", 32'(out_valid), 32'h0);
        chk("rm_gnt", 32'(in_ready),  32'b0001);
        nxt();
        chk("rm_sel",  32'(out_sel),  32'h0);
        chk("rm_data", 32'(out_data), 32'h40);
        chk("rm_gnt2", 32'(in_ready), 32'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
